ram_port_arbiter: RTL

Sequences and shares the single-port 32x8 on-chip RAM (`ramlpm`) between two requesters: a write port (switch/user entry) and a read port (display scan).
- Grants one access at a time and drives the RAM address, data and write-enable from registers.
- Tracks RAM read latency and returns read data with a valid strobe.
- Sits between the board-level control logic and the RAM instance; replaces ad-hoc write/read muxing in the top level.

---
 rtl/ram_port_arbiter_if.sv | 30 +++
 rtl/ram_port_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter.
// master = write/read requesters, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr_q;

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr,
    input  wr_ack, rd_valid,
    input  rd_data, rd_addr_q
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr,
    output wr_ack, rd_valid,
    output rd_data, rd_addr_q
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between a write and a read port.
// `RAM_ARB_ROUND_ROBIN_EN selects round-robin over write priority.
module ram_port_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
  output logic [AW-1:0]     ram_address,
  output logic [DW-1:0]     ram_data,
  output logic              ram_wren,
  input  logic [DW-1:0]     ram_q,
  output logic              busy
);
  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RWAIT
  } state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] lat_cnt;
  logic       rd_live;
  logic       pick_wr;
  logic       grant_wr;
  logic       grant_rd;
  logic       lat_done;

  // the finished read is still held during its valid cycle
  assign rd_live  = bus.rd_req & ~bus.rd_valid;
  assign lat_done = (lat_cnt == 2'd0);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_rd;

  assign pick_wr = bus.wr_req & (~rd_live | last_rd);

  // remember which port was served last
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      last_rd <= 1'b1;
    end else if (grant_wr) begin
      last_rd <= 1'b0;
    end else if (grant_rd) begin
      last_rd <= 1'b1;
    end
  end
`else
  assign pick_wr = bus.wr_req;
`endif

  // next state and grant decode
  always_comb begin
    state_nx = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_wr) begin
          grant_wr = 1'b1;
          state_nx = WR;
        end else if (rd_live) begin
          grant_rd = 1'b1;
          state_nx = RD;
        end
      end
      WR:      state_nx = IDLE;
      RD:      state_nx = RWAIT;
      RWAIT:   if (lat_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // read latency countdown
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      lat_cnt <= 2'd0;
    end else if (state == RD) begin
      lat_cnt <= LAT_LOAD;
    end else if (state == RWAIT && !lat_done) begin
      lat_cnt <= lat_cnt - 2'd1;
    end
  end

  // RAM address/data registers, loaded on grant
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      ram_address <= '0;
      ram_data    <= '0;
    end else if (grant_wr) begin
      ram_address <= bus.wr_addr;
      ram_data    <= bus.wr_data;
    end else if (grant_rd) begin
      ram_address <= bus.rd_addr;
    end
  end

  // capture read data once the RAM latency has elapsed
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_addr_q <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (state == RWAIT && lat_done) begin
        bus.rd_valid  <= 1'b1;
        bus.rd_data   <= ram_q;
        bus.rd_addr_q <= ram_address;
      end
    end
  end

  assign ram_wren   = (state == WR);
  assign bus.wr_ack = (state == WR);
  assign busy       = (state != IDLE);

endmodule
